systolic_top: RTL and testbench



---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_pe.sv | 46 ++++
 rtl/systolic_top.sv | 189 ++++++++++++++++++
 tb/tb_systolic_top.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply engine.
package systolic_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      DRAIN   = 2'd2
   } state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell: registers a/b (with valid tags) onward and
// accumulates a*b once for each cycle both incoming operands are valid.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int width_p = 8
) (
   input  logic               clk_sys,
   input  logic               rst_b,
   input  logic               en,
   input  logic               clr,
   input  logic [width_p-1:0] a_in,
   input  logic               a_vin,
   input  logic [width_p-1:0] b_in,
   input  logic               b_vin,
   output logic [width_p-1:0] a_out,
   output logic               a_vout,
   output logic [width_p-1:0] b_out,
   output logic               b_vout,
   output logic [width_p-1:0] acc
);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         a_out  <= '0;
         a_vout <= 1'b0;
         b_out  <= '0;
         b_vout <= 1'b0;
         acc    <= '0;
      end else if (clr) begin
         a_out  <= '0;
         a_vout <= 1'b0;
         b_out  <= '0;
         b_vout <= 1'b0;
         acc    <= '0;
      end else if (en) begin
         a_out  <= a_in;
         a_vout <= a_vin;
         b_out  <= b_in;
         b_vout <= b_vin;
         // modulo 2^width_p: product and sum truncate to the accumulator width
         if (a_vin && b_vin) acc <= acc + a_in * b_in;
      end
   end

endmodule

// File: rtl/systolic_top.sv
// Streaming H x W systolic outer-product engine: loads H row and W column
// operands, skews them through the PE grid, then drains results column-major.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   LOAD    | accept operand words (one per two cycles), rows first
//   COMPUTE | H+W-1 cycles of skewed propagation, each PE accumulates once
//   DRAIN   | present acc[r][c] for k = c*H + r, advance on yumi_i
module systolic_top
   import systolic_pkg::*;
#(
   parameter int width_p        = 8,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic               flush_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               valid_o,
   input  logic               yumi_i,
   output logic [width_p-1:0] data_o
);

   localparam int H   = array_height_p;
   localparam int W   = array_width_p;
   localparam int LW  = cnt_w(H + W);
   localparam int RW  = cnt_w(H);
   localparam int CLW = cnt_w(W);

   localparam logic [LW-1:0]  LOAD_LAST = LW'(H + W - 1);
   localparam logic [LW-1:0]  COMP_INIT = LW'(H + W - 2);
   localparam logic [RW-1:0]  R_LAST    = RW'(H - 1);
   localparam logic [CLW-1:0] C_LAST    = CLW'(W - 1);

   state_e             state_q, state_d;
   logic               gap_q;
   logic [LW-1:0]      load_cnt_q;
   logic [LW-1:0]      comp_cnt_q;
   logic [RW-1:0]      dr_r_q;
   logic [CLW-1:0]     dr_c_q;
   logic [width_p-1:0] a_op_q [H];
   logic [width_p-1:0] b_op_q [W];

   logic accept, load_last, comp_last, take, drain_last, inject;

   logic [width_p-1:0] a_h  [H][W+1];
   logic               va_h [H][W+1];
   logic [width_p-1:0] b_v  [H+1][W];
   logic               vb_v [H+1][W];
   logic [width_p-1:0] acc_g [H][W];

   assign ready_o    = reset_i & en_i & (state_q == LOAD) & ~gap_q;
   assign valid_o    = reset_i & en_i & (state_q == DRAIN);
   assign accept     = ready_o & valid_i & ~flush_i;
   assign load_last  = accept & (load_cnt_q == LOAD_LAST);
   assign comp_last  = en_i & (state_q == COMPUTE) & (comp_cnt_q == '0);
   assign take       = valid_o & yumi_i & ~flush_i;
   assign drain_last = take & (dr_r_q == R_LAST) & (dr_c_q == C_LAST);
   assign inject     = (state_q == COMPUTE) & (comp_cnt_q == COMP_INIT);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (load_last)  state_d = COMPUTE;
         COMPUTE: if (comp_last)  state_d = DRAIN;
         DRAIN:   if (drain_last) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)     state_q <= LOAD;
      else if (flush_i) state_q <= LOAD;
      else              state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         gap_q      <= 1'b0;
         load_cnt_q <= '0;
         comp_cnt_q <= '0;
         dr_r_q     <= '0;
         dr_c_q     <= '0;
         for (int i = 0; i < H; i++) a_op_q[i] <= '0;
         for (int i = 0; i < W; i++) b_op_q[i] <= '0;
      end else if (flush_i) begin
         gap_q      <= 1'b0;
         load_cnt_q <= '0;
         comp_cnt_q <= '0;
         dr_r_q     <= '0;
         dr_c_q     <= '0;
         for (int i = 0; i < H; i++) a_op_q[i] <= '0;
         for (int i = 0; i < W; i++) b_op_q[i] <= '0;
      end else if (en_i) begin
         gap_q <= accept;
         if (accept) begin
            load_cnt_q <= load_last ? '0 : load_cnt_q + LW'(1);
            for (int i = 0; i < H; i++)
               if (load_cnt_q == LW'(i)) a_op_q[i] <= data_i;
            for (int i = 0; i < W; i++)
               if (load_cnt_q == LW'(H + i)) b_op_q[i] <= data_i;
         end
         // compute timer counts down to a terminal zero
         if (load_last)
            comp_cnt_q <= COMP_INIT;
         else if ((state_q == COMPUTE) && (comp_cnt_q != '0))
            comp_cnt_q <= comp_cnt_q - LW'(1);
         if (take) begin
            if (dr_r_q == R_LAST) begin
               dr_r_q <= '0;
               dr_c_q <= (dr_c_q == C_LAST) ? '0 : dr_c_q + CLW'(1);
            end else begin
               dr_r_q <= dr_r_q + RW'(1);
            end
         end
      end
   end

   for (genvar r = 0; r < H; r++) begin : g_row
      logic [width_p-1:0] a_inj;
      assign a_inj = inject ? a_op_q[r] : '0;
      if (r == 0) begin : g_direct
         assign va_h[r][0] = inject;
         assign a_h[r][0]  = a_inj;
      end else begin : g_skew
         logic [width_p:0] sk_q [r];
         always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
               for (int i = 0; i < r; i++) sk_q[i] <= '0;
            end else if (flush_i) begin
               for (int i = 0; i < r; i++) sk_q[i] <= '0;
            end else if (en_i) begin
               sk_q[0] <= {inject, a_inj};
               for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
            end
         end
         assign {va_h[r][0], a_h[r][0]} = sk_q[r-1];
      end
   end

   for (genvar c = 0; c < W; c++) begin : g_col
      logic [width_p-1:0] b_inj;
      assign b_inj = inject ? b_op_q[c] : '0;
      if (c == 0) begin : g_direct
         assign vb_v[0][c] = inject;
         assign b_v[0][c]  = b_inj;
      end else begin : g_skew
         logic [width_p:0] sk_q [c];
         always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
               for (int i = 0; i < c; i++) sk_q[i] <= '0;
            end else if (flush_i) begin
               for (int i = 0; i < c; i++) sk_q[i] <= '0;
            end else if (en_i) begin
               sk_q[0] <= {inject, b_inj};
               for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
            end
         end
         assign {vb_v[0][c], b_v[0][c]} = sk_q[c-1];
      end
   end

   for (genvar r = 0; r < H; r++) begin : g_pe_r
      for (genvar c = 0; c < W; c++) begin : g_pe_c
         systolic_pe #(.width_p(width_p)) u_pe (
            .clk_sys (clk_i),
            .rst_b   (reset_i),
            .en      (en_i),
            .clr     (flush_i),
            .a_in    (a_h[r][c]),
            .a_vin   (va_h[r][c]),
            .b_in    (b_v[r][c]),
            .b_vin   (vb_v[r][c]),
            .a_out   (a_h[r][c+1]),
            .a_vout  (va_h[r][c+1]),
            .b_out   (b_v[r+1][c]),
            .b_vout  (vb_v[r+1][c]),
            .acc     (acc_g[r][c])
         );
      end
   end

   assign data_o = valid_o ? acc_g[dr_r_q][dr_c_q] : '0;

endmodule

// File: tb/tb_systolic_top.sv
// Directed bench for systolic_top (2x2, 8-bit) with hand-computed results.
module tb_systolic_top;

   logic       clk = 1'b0;
   logic       reset_i, en_i, flush_i, valid_i, ready_o, valid_o, yumi_i;
   logic [7:0] data_i, data_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int last_acc = 0;
   int n_acc    = 0;

   always #5 clk = ~clk;

   systolic_top #(.width_p(8), .array_width_p(2), .array_height_p(2)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .en_i    (en_i),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .valid_o (valid_o),
      .yumi_i  (yumi_i),
      .data_o  (data_o)
   );

   always @(posedge clk) begin
      cyc++;
      if (reset_i && en_i && !flush_i && valid_i && ready_o) begin
         n_acc++;
         last_acc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic flush_pulse;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
   endtask

   task automatic load4(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3);
      logic [7:0] w [4];
      w = '{w0, w1, w2, w3};
      n_acc = 0;
      for (int i = 0; i < 4; i++) begin
         valid_i = 1'b1;
         data_i  = w[i];
         step();
         step();
      end
      valid_i = 1'b0;
      data_i  = '0;
      check({tag, "_accepted"}, n_acc, 4);
   endtask

   task automatic wait_valid(input string tag, input int exp_lat);
      int k;
      k = 0;
      while (!valid_o && k < 60) begin
         step();
         k++;
      end
      check({tag, "_valid"}, valid_o, 1);
      check({tag, "_latency"}, cyc - last_acc, exp_lat);
   endtask

   task automatic drain4(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input int gate_at);
      logic [7:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         if (i == gate_at) begin
            en_i = 1'b0;
            for (int j = 0; j < 5; j++) begin
               #1;
               check($sformatf("%s_gate_valid%0d", tag, j), valid_o, 0);
               check($sformatf("%s_gate_ready%0d", tag, j), ready_o, 0);
               @(negedge clk);
               #1;
            end
            en_i = 1'b1;
            #1;
         end
         check($sformatf("%s_v%0d", tag, i), valid_o, 1);
         check($sformatf("%s_w%0d", tag, i), data_o, e[i]);
         yumi_i = 1'b1;
         step();
      end
      yumi_i = 1'b0;
      check({tag, "_done_valid"}, valid_o, 0);
      check({tag, "_done_ready"}, ready_o, 1);
   endtask

   initial begin
      reset_i = 1'b0;
      en_i    = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      yumi_i  = 1'b0;
      data_i  = '0;
      step();
      step();
      check("rst_ready", ready_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 0);
      reset_i = 1'b1;
      step();
      check("post_rst_ready", ready_o, 1);
      check("post_rst_valid", valid_o, 0);

      load4("single", 8'd3, 8'd4, 8'd2, 8'd4);
      wait_valid("single", 3);
      drain4("single", 8'd6, 8'd8, 8'd12, 8'd16, -1);

      flush_pulse();
      load4("mm_p1", 8'd1, 8'd3, 8'd1, 8'd2);
      wait_valid("mm_p1", 3);
      drain4("mm_p1", 8'd1, 8'd3, 8'd2, 8'd6, -1);
      load4("mm_p2", 8'd2, 8'd4, 8'd3, 8'd4);
      wait_valid("mm_p2", 3);
      drain4("mm_p2", 8'd7, 8'd15, 8'd10, 8'd22, -1);

      flush_pulse();
      load4("trunc", 8'd255, 8'd16, 8'd2, 8'd16);
      wait_valid("trunc", 3);
      drain4("trunc", 8'd254, 8'd32, 8'd240, 8'd0, -1);

      flush_pulse();
      load4("fl", 8'd1, 8'd2, 8'd3, 8'd4);
      wait_valid("fl", 3);
      check("fl_w0", data_o, 3);
      yumi_i = 1'b1;
      step();
      check("fl_w1", data_o, 6);
      step();
      yumi_i  = 1'b0;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("fl_valid_after", valid_o, 0);
      check("fl_data_after", data_o, 0);
      check("fl_ready_after", ready_o, 1);
      load4("fl_fresh", 8'd1, 8'd1, 8'd1, 8'd1);
      wait_valid("fl_fresh", 3);
      drain4("fl_fresh", 8'd1, 8'd1, 8'd1, 8'd1, -1);

      flush_pulse();
      load4("gate", 8'd3, 8'd4, 8'd2, 8'd4);
      en_i = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         check($sformatf("gate_cmp_valid%0d", j), valid_o, 0);
         check($sformatf("gate_cmp_ready%0d", j), ready_o, 0);
         @(negedge clk);
         #1;
      end
      en_i = 1'b1;
      wait_valid("gate", 8);
      drain4("gate", 8'd6, 8'd8, 8'd12, 8'd16, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
